// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter shared by instruction fetch and the load/store path.
// Each 1/2/4-byte access is split into byte cycles; read data is assembled little-endian.
module mem_ctrl #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned IF_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic [1:0]        mem_read_req_i,
    input  logic [1:0]        mem_write_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q;
    logic              owner_mem_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        size_q;
    logic [2:0]        cnt_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic              req_mem, req_write, req_any;
    logic [1:0]        sel_sz;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        cnt_inc;
    logic [1:0]        cap_idx;
    logic [31:0]       data_nxt;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b01:   size_of = 3'd1;
            2'b10:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    always_comb begin
        req_mem   = (mem_read_req_i != 2'b00) || (mem_write_req_i != 2'b00);
        req_write = mem_write_req_i != 2'b00;
        req_any   = req_mem || if_req_i;
        sel_sz    = req_write ? mem_write_req_i : mem_read_req_i;
        req_size  = req_mem ? size_of(sel_sz) : 3'(IF_BYTES);
        req_addr  = req_mem ? mem_addr_i : if_addr_i;
        cnt_inc   = cnt_q + 3'd1;
        // cnt_q counts elapsed RD cycles; the byte arriving now was addressed one cycle earlier
        cap_idx   = 2'(cnt_q - 3'd1);
        data_nxt  = data_q;
        data_nxt[{cap_idx, 3'b000} +: 8] = ram_din_i;
    end

    assign busy_o = state_q != StIdle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            if_data_o   <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            ram_a_o     <= '0;
            ram_dout_o  <= '0;
            ram_wr_o    <= 1'b0;
        end else begin
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q    <= StIdle;
                    ram_wr_o   <= 1'b0;
                    ram_a_o    <= '0;
                    ram_dout_o <= '0;
                    if (req_any) begin
                        state_q     <= req_write ? StWr : StRd;
                        owner_mem_q <= req_mem;
                        base_q      <= req_addr;
                        size_q      <= req_size;
                        wdata_q     <= mem_wdata_i;
                        cnt_q       <= '0;
                        data_q      <= '0;
                        ram_a_o     <= req_addr;
                        ram_wr_o    <= req_write;
                        ram_dout_o  <= req_write ? mem_wdata_i[7:0] : 8'h00;
                    end
                end
                StRd: begin
                    if (!owner_mem_q && !if_req_i) begin
                        // branch flush: abandon the fetch silently
                        state_q <= StIdle;
                        ram_a_o <= '0;
                    end else begin
                        cnt_q   <= cnt_inc;
                        ram_a_o <= (cnt_inc < size_q) ? base_q + ADDR_W'(cnt_inc) : '0;
                        if (cnt_q != 3'd0) data_q <= data_nxt;
                        if (cnt_q == size_q) begin
                            state_q <= StDone;
                            if (owner_mem_q) begin
                                mem_done_o  <= 1'b1;
                                mem_rdata_o <= data_nxt;
                            end else begin
                                if_done_o <= 1'b1;
                                if_data_o <= data_nxt;
                            end
                        end
                    end
                end
                StWr: begin
                    if (cnt_inc < size_q) begin
                        cnt_q      <= cnt_inc;
                        ram_a_o    <= base_q + ADDR_W'(cnt_inc);
                        ram_dout_o <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                    end else begin
                        state_q    <= StDone;
                        ram_wr_o   <= 1'b0;
                        ram_a_o    <= '0;
                        ram_dout_o <= '0;
                        mem_done_o <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of MEM transfers against a byte RAM model,
// plus hand sequences for arbitration, address wrap, IF abort and mid-write reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [16:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic [1:0]  mem_read_req, mem_write_req;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_done;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_wr, busy;

    bit   [7:0]  ram [0:131071];
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(17), .IF_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
        .mem_read_req_i(mem_read_req), .mem_write_req_i(mem_write_req),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
        .mem_done_o(mem_done), .ram_a_o(ram_a), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr),
        .ram_din_i(ram_din), .busy_o(busy)
    );

    // RAM model: data for the address of cycle c appears during cycle c+1
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    task automatic mem_xfer(input logic [1:0] wr_sz, input logic [1:0] rd_sz,
                            input logic [16:0] addr, input logic [31:0] wd,
                            output int done_cyc, output logic [31:0] rdata, output int err);
        int n;
        logic is_wr;
        logic [16:0] ea;
        logic [31:0] sh;
        is_wr = wr_sz != 2'b00;
        n = nbytes(is_wr ? wr_sz : rd_sz);
        done_cyc = -1; rdata = 'x; err = 0;
        mem_write_req = wr_sz; mem_read_req = rd_sz; mem_addr = addr; mem_wdata = wd;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (cyc < n) begin
                ea = addr + 17'(cyc);
                sh = wd >> (8 * cyc);
                if (ram_a !== ea || ram_wr !== is_wr) err++;
                if (is_wr && ram_dout !== sh[7:0]) err++;
            end
            if (if_done) err++;
            if (mem_done) begin
                done_cyc = cyc;
                rdata = mem_rdata;
                if (ram_wr || if_data !== 32'h0) err++;
                mem_write_req = 2'b00; mem_read_req = 2'b00; mem_wdata = '0;
                break;
            end
        end
        mem_write_req = 2'b00; mem_read_req = 2'b00;
    endtask

    typedef struct {
        logic [1:0]  wr_sz;
        logic [1:0]  rd_sz;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dc, err, mem_cyc, if_cyc, both, ndone;
        logic [31:0] rd, mdat, idat;

        vecs[0] = '{2'b00, 2'b11, 17'h00010, 32'h0,        32'h44332211, 5};
        vecs[1] = '{2'b10, 2'b00, 17'h00020, 32'hDEADBEEF, 32'h0,        2};
        vecs[2] = '{2'b00, 2'b01, 17'h00021, 32'h0,        32'h000000BE, 2};
        vecs[3] = '{2'b00, 2'b10, 17'h00020, 32'h0,        32'h0000BEEF, 3};
        vecs[4] = '{2'b11, 2'b00, 17'h1FFFE, 32'h01020304, 32'h0,        4};
        vecs[5] = '{2'b00, 2'b11, 17'h1FFFE, 32'h0,        32'h01020304, 5};
        vecs[6] = '{2'b01, 2'b11, 17'h00030, 32'h12345677, 32'h0,        1};
        vecs[7] = '{2'b00, 2'b01, 17'h00030, 32'h0,        32'h00000077, 2};

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_read_req = 2'b00; mem_write_req = 2'b00; mem_addr = '0; mem_wdata = '0;
        tick();
        preload(17'h00010, 8'h11); preload(17'h00011, 8'h22);
        preload(17'h00012, 8'h33); preload(17'h00013, 8'h44);
        preload(17'h00040, 8'hA0); preload(17'h00041, 8'hB1);
        preload(17'h00042, 8'hC2); preload(17'h00043, 8'hD3);
        check("reset_outputs",
              {if_data, mem_rdata}, 64'h0);
        check("reset_ctrl",
              {if_done, mem_done, ram_wr, busy, ram_a, ram_dout}, 64'h0);
        rst = 1'b0;

        // table-driven MEM transfers, issued back-to-back
        foreach (vecs[i]) begin
            mem_xfer(vecs[i].wr_sz, vecs[i].rd_sz, vecs[i].addr, vecs[i].wdata, dc, rd, err);
            check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vecs[i].exp_done));
            if (vecs[i].wr_sz == 2'b00) check($sformatf("vec%0d_rdata", i), 64'(rd),
                                              64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_bus_errors", i), 64'(err), 64'h0);
        end
        check("half_write_byte0", 64'(ram[17'h00020]), 64'hEF);
        check("half_write_untouched", 64'(ram[17'h00022]), 64'h00);
        check("wrap_write_low", 64'(ram[17'h00001]), 64'h01);
        tick();

        // MEM and IF arrive together: MEM first, IF accepted right after DONE
        if_req = 1'b1; if_addr = 17'h00040;
        mem_read_req = 2'b01; mem_addr = 17'h00010;
        mem_cyc = -1; if_cyc = -1; both = 0; mdat = 'x; idat = 'x;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (mem_done && if_done) both++;
            if (mem_done) begin
                mem_cyc = cyc; mdat = mem_rdata; mem_read_req = 2'b00;
            end
            if (if_done) begin
                if_cyc = cyc; idat = if_data; if_req = 1'b0;
                if (mem_rdata !== 32'h0) both++;
                break;
            end
        end
        if_req = 1'b0; mem_read_req = 2'b00;
        check("arb_mem_done_cycle", 64'(mem_cyc), 64'd2);
        check("arb_mem_rdata", 64'(mdat), 64'h11);
        check("arb_if_done_cycle", 64'(if_cyc), 64'd8);
        check("arb_if_data", 64'(idat), 64'hD3C2B1A0);
        check("arb_exclusive", 64'(both), 64'h0);
        tick();

        // IF fetch across the top of the address space
        if_req = 1'b1; if_addr = 17'h1FFFE;
        if_cyc = -1; err = 0; idat = 'x;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (cyc < 4 && (ram_a !== 17'(17'h1FFFE + 17'(cyc)) || ram_wr !== 1'b0)) err++;
            if (mem_done) err++;
            if (if_done) begin
                if_cyc = cyc; idat = if_data; if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0;
        check("if_wrap_done_cycle", 64'(if_cyc), 64'd5);
        check("if_wrap_data", 64'(idat), 64'h01020304);
        check("if_wrap_addr_walk", 64'(err), 64'h0);
        tick();

        // IF abort after two cycles, then a store
        if_req = 1'b1; if_addr = 17'h00010;
        tick(); tick();
        if_req = 1'b0;
        tick();
        check("abort_idle", {63'h0, busy}, 64'h0);
        check("abort_addr", 64'(ram_a), 64'h0);
        ndone = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (if_done || mem_done) ndone++;
            tick();
        end
        check("abort_no_done", 64'(ndone), 64'h0);
        mem_xfer(2'b01, 2'b00, 17'h00050, 32'h00000055, dc, rd, err);
        check("post_abort_store_done", 64'(dc), 64'd1);
        check("post_abort_store_data", 64'(ram[17'h00050]), 64'h55);
        tick();

        // reset during the third byte of a word write
        mem_write_req = 2'b11; mem_addr = 17'h00060; mem_wdata = 32'h0A0B0C0D;
        tick(); tick(); tick();
        check("pre_reset_writing", {63'h0, ram_wr}, 64'h1);
        rst = 1'b1; mem_write_req = 2'b00; mem_wdata = '0;
        tick();
        check("mid_reset_outputs", {if_data, mem_rdata}, 64'h0);
        check("mid_reset_ctrl", {if_done, mem_done, ram_wr, busy, ram_a, ram_dout}, 64'h0);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (mem_done || if_done || busy) ndone++;
        end
        check("mid_reset_no_done", 64'(ndone), 64'h0);
        check("partial_write_kept", 64'(ram[17'h00062]), 64'h0B);
        check("partial_write_stops", 64'(ram[17'h00063]), 64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
